// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of {pc, inst} entries with flush; head and valid come straight from flops.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         push_in,
  input  fetch_entry_t push_entry_in,
  input  logic         flush_in,
  input  logic         pop_ready_in,
  output logic         full_out,
  output logic         head_valid_out,
  output fetch_entry_t head_out
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  fetch_entry_t     mem_q [QUEUE_DEPTH];
  fetch_entry_t     mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;

  assign head_valid_out = (count_q != '0);
  assign full_out       = (count_q == CNT_W'(QUEUE_DEPTH));
  assign pop            = head_valid_out && pop_ready_in;
  assign head_out       = head_valid_out ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over a same-cycle push or pop.
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_in) begin
        mem_d[wr_ptr_q] = push_entry_in;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_in, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_in && !flush_in) begin
      assert (!(push_in && full_out && !pop))
        else $error("fetch_queue: push while full");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding imem request, sole writer of the PC register,
// redirect/flush from execute. Handshake: a request transfers when valid && ready in one cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next_out,
  output logic        pc_write_out,
  output logic        imem_req_valid_out,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_req_ready_in,
  input  logic        imem_resp_valid_in,
  input  logic [31:0] imem_resp_data_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_addr_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
  input  logic        inst_ready_in
);

  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         push;
  logic         flush;
  logic         q_full;
  fetch_entry_t resp_entry;
  fetch_entry_t head;

  always_comb begin
    state_d            = state_q;
    req_pc_d           = req_pc_q;
    push               = 1'b0;
    flush              = 1'b0;
    imem_req_valid_out = 1'b0;
    pc_write_out       = 1'b0;
    pc_next_out        = '0;
    if (!reset_in) begin
      if (redirect_valid_in) begin
        pc_write_out = 1'b1;
        pc_next_out  = word_align(redirect_addr_in);
        flush        = 1'b1;
        // A request in flight becomes squashed; its response is swallowed in DRAIN.
        if (state_q == WAIT) begin
          state_d = imem_resp_valid_in ? REQ : DRAIN;
        end
      end else begin
        case (state_q)
          REQ: begin
            imem_req_valid_out = !q_full;
            if (!q_full && imem_req_ready_in) begin
              pc_write_out = 1'b1;
              pc_next_out  = pc_in + PC_INCR;
              req_pc_d     = pc_in;
              state_d      = WAIT;
            end
          end
          WAIT: begin
            if (imem_resp_valid_in) begin
              push    = 1'b1;
              state_d = REQ;
            end
          end
          DRAIN: begin
            if (imem_resp_valid_in) begin
              state_d = REQ;
            end
          end
          default: state_d = REQ;
        endcase
      end
    end
  end

  assign imem_req_addr_out = imem_req_valid_out ? pc_in : '0;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q  <= REQ;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign resp_entry = '{pc: req_pc_q, inst: imem_resp_data_in};

  fetch_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk           (clk),
    .reset_in      (reset_in),
    .push_in       (push),
    .push_entry_in (resp_entry),
    .flush_in      (flush),
    .pop_ready_in  (inst_ready_in),
    .full_out      (q_full),
    .head_valid_out(inst_valid_out),
    .head_out      (head)
  );

  assign inst_out    = head.inst;
  assign inst_pc_out = head.pc;

  always_ff @(posedge clk) begin
    if (!reset_in && state_q == REQ) begin
      assert (!imem_resp_valid_in)
        else $error("fetch_unit: response with no outstanding request");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked each cycle
// against a transaction-level model of the PC, outstanding request and instruction queue.
module tb_fetch_unit;

  localparam int DEPTH    = 2;
  localparam int NONE     = 0;
  localparam int LIVE     = 1;
  localparam int SQUASHED = 2;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] pc_in;
  logic [31:0] pc_next_out;
  logic        pc_write_out;
  logic        imem_req_valid_out;
  logic [31:0] imem_req_addr_out;
  logic        imem_req_ready_in;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_addr_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        inst_ready_in;

  always #5 clk = ~clk;

  fetch_unit #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_in          (reset_in),
    .pc_in             (pc_in),
    .pc_next_out       (pc_next_out),
    .pc_write_out      (pc_write_out),
    .imem_req_valid_out(imem_req_valid_out),
    .imem_req_addr_out (imem_req_addr_out),
    .imem_req_ready_in (imem_req_ready_in),
    .imem_resp_valid_in(imem_resp_valid_in),
    .imem_resp_data_in (imem_resp_data_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_addr_in  (redirect_addr_in),
    .inst_valid_out    (inst_valid_out),
    .inst_out          (inst_out),
    .inst_pc_out       (inst_pc_out),
    .inst_ready_in     (inst_ready_in)
  );

  int n_checks = 0;
  int n_errors = 0;

  // stimulus knobs
  logic        rst   = 1'b1;
  logic        rdy   = 1'b1;
  logic        irdy  = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] raddr = '0;
  int          lat   = 1;

  // reference model: expected queue of {pc, inst}, PC register, outstanding request
  logic [63:0] exp_q[$];
  logic [31:0] mdl_pc     = '0;
  logic [31:0] mdl_req_pc = '0;
  int          mdl_out    = NONE;

  // memory environment
  logic mem_pending = 1'b0;
  int   mem_cnt     = 0;

  // observations of the latest cycle
  logic        last_hs, last_rv, last_pw, last_iv;
  logic [31:0] last_ra, last_pn, last_ipc;
  logic [31:0] deliv_q[$];
  int          n_pw = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic cycle();
    logic        resp_v, redir_eff, e_rv, e_pw, e_iv, pop, hs;
    logic [31:0] resp_d, e_ra, e_pn, e_inst, e_ipc;
    @(negedge clk);
    resp_v    = mem_pending && (mem_cnt == 0) && !rst;
    resp_d    = $urandom();
    redir_eff = redir && !(resp_v && mdl_out == SQUASHED);
    reset_in           = rst;
    pc_in              = mdl_pc;
    imem_req_ready_in  = rdy;
    imem_resp_valid_in = resp_v;
    imem_resp_data_in  = resp_d;
    redirect_valid_in  = redir_eff;
    redirect_addr_in   = raddr;
    inst_ready_in      = irdy;
    #1;
    e_rv = 1'b0; e_ra = '0; e_pw = 1'b0; e_pn = '0;
    if (rst) begin
      e_rv = 1'b0;
    end else if (redir_eff) begin
      e_pw = 1'b1;
      e_pn = raddr & 32'hFFFF_FFFC;
    end else if (mdl_out == NONE) begin
      e_rv = (exp_q.size() < DEPTH);
      e_ra = e_rv ? mdl_pc : 32'd0;
      e_pw = e_rv && rdy;
      e_pn = e_pw ? mdl_pc + 32'd4 : 32'd0;
    end
    e_iv   = (exp_q.size() > 0);
    e_inst = e_iv ? exp_q[0][31:0]  : 32'd0;
    e_ipc  = e_iv ? exp_q[0][63:32] : 32'd0;
    chk("req_valid", 32'(imem_req_valid_out), 32'(e_rv));
    chk("req_addr",  imem_req_addr_out,       e_ra);
    chk("pc_write",  32'(pc_write_out),       32'(e_pw));
    chk("pc_next",   pc_next_out,             e_pn);
    if (!rst) begin
      chk("inst_valid", 32'(inst_valid_out), 32'(e_iv));
      chk("inst",       inst_out,            e_inst);
      chk("inst_pc",    inst_pc_out,         e_ipc);
    end
    hs       = imem_req_valid_out && imem_req_ready_in;
    last_hs  = hs;
    last_rv  = imem_req_valid_out;
    last_ra  = imem_req_addr_out;
    last_pw  = pc_write_out;
    last_pn  = pc_next_out;
    last_iv  = inst_valid_out;
    last_ipc = inst_pc_out;
    if (pc_write_out) n_pw++;
    if (!rst && inst_valid_out && irdy) deliv_q.push_back(inst_pc_out);
    @(posedge clk);
    pop = e_iv && irdy;
    if (rst) begin
      exp_q.delete();
      mdl_out = NONE;
      mdl_pc  = '0;
    end else if (redir_eff) begin
      exp_q.delete();
      mdl_pc = raddr & 32'hFFFF_FFFC;
      if (mdl_out == LIVE) mdl_out = resp_v ? NONE : SQUASHED;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (mdl_out == NONE && e_pw) begin
        mdl_out    = LIVE;
        mdl_req_pc = mdl_pc;
        mdl_pc     = mdl_pc + 32'd4;
      end else if (mdl_out == LIVE && resp_v) begin
        exp_q.push_back({mdl_req_pc, resp_d});
        mdl_out = NONE;
      end else if (mdl_out == SQUASHED && resp_v) begin
        mdl_out = NONE;
      end
    end
    if (rst) begin
      mem_pending = 1'b0;
    end else begin
      if (resp_v) mem_pending = 1'b0;
      else if (mem_pending && mem_cnt > 0) mem_cnt--;
      if (hs) begin
        mem_pending = 1'b1;
        mem_cnt     = lat - 1;
      end
    end
  endtask

  task automatic wait_out(input int st, input string tag);
    for (int i = 0; i < 40 && mdl_out != st; i++) cycle();
    chk(tag, 32'(mdl_out), 32'(st));
  endtask

  task automatic wait_hs(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = last_hs;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;

    // sequential fetch with single-cycle memory and a free-running decoder
    n_pw = 0; deliv_q.delete(); lat = 1; rdy = 1'b1; irdy = 1'b1;
    repeat (9) cycle();
    chk("seq_pc_writes", 32'(n_pw), 32'd5);
    chk("seq_deliv_cnt", 32'(deliv_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("seq_deliv_pc", (i < deliv_q.size()) ? deliv_q[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // decode stall fills the queue, then release resumes at PC 8
    rst = 1'b1; cycle(); rst = 1'b0;
    irdy = 1'b0;
    repeat (8) cycle();
    chk("stall_req_valid", 32'(last_rv), 32'd0);
    chk("stall_head_valid", 32'(last_iv), 32'd1);
    chk("stall_head_pc", last_ipc, 32'd0);
    irdy = 1'b1;
    wait_hs("resume_hs_timeout");
    chk("resume_addr", last_ra, 32'd8);

    // redirect while waiting; late response is drained
    wait_out(NONE, "redir_idle_timeout");
    lat = 3;
    wait_out(LIVE, "redir_live_timeout");
    redir = 1'b1; raddr = 32'h0000_0103;
    cycle();
    redir = 1'b0;
    chk("redir_pc_write", 32'(last_pw), 32'd1);
    chk("redir_pc_next", last_pn, 32'h0000_0100);
    wait_hs("drain_hs_timeout");
    chk("drain_next_addr", last_ra, 32'h0000_0100);

    // redirect in the same cycle as the response
    wait_out(NONE, "same_idle_timeout");
    lat = 1;
    wait_out(LIVE, "same_live_timeout");
    redir = 1'b1; raddr = 32'h0000_0200;
    cycle();
    redir = 1'b0;
    cycle();
    chk("same_inst_valid", 32'(last_iv), 32'd0);
    chk("same_req_valid", 32'(last_rv), 32'd1);
    chk("same_req_addr", last_ra, 32'h0000_0200);

    // PC wrap
    wait_out(NONE, "wrap_idle_timeout");
    redir = 1'b1; raddr = 32'hFFFF_FFFC;
    cycle();
    redir = 1'b0;
    wait_hs("wrap_hs_timeout");
    chk("wrap_addr", last_ra, 32'hFFFF_FFFC);
    chk("wrap_pc_next", last_pn, 32'h0000_0000);

    // reset while waiting with one entry queued
    rst = 1'b1; cycle(); rst = 1'b0;
    irdy = 1'b0; lat = 3;
    for (int i = 0; i < 40 && !(exp_q.size() == 1 && mdl_out == LIVE); i++) cycle();
    chk("rstwait_setup_timeout", 32'(last_iv && mdl_out == LIVE), 32'd1);
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_inst_valid", 32'(inst_valid_out), 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc_out, 32'd0);
    rst = 1'b0; irdy = 1'b1;
    wait_hs("post_rst_hs_timeout");
    chk("post_rst_addr", last_ra, 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      irdy  = ($urandom_range(0, 2) != 0);
      lat   = $urandom_range(1, 3);
      redir = ($urandom_range(0, 15) == 0);
      raddr = $urandom();
      rst   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; redir = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit sitting on the read side of the program counter register: it consumes the current PC, issues word requests to instruction memory, and buffers returned instructions, tagged with their PC, for the decode stage. It is also the sole writer of the PC register, driving its next-address and write-enable inputs for both sequential advance (PC+4) and branch/jump redirects from execute. It allows one outstanding memory request and provides a small in-order instruction queue with flush.

## Interface
- QUEUE_DEPTH, 2, instruction queue entries (≥2, power of two)
- clk  input  1  system clock, all state on rising edge
- reset_in  input  1  synchronous, active-high reset
- pc_in  input  32  current PC from PC register
- pc_next_out  output  32  next-address to PC register
- pc_write_out  output  1  PC register write enable
- imem_req_valid_out  output  1  memory request valid
- imem_req_addr_out  output  32  request word address
- imem_req_ready_in  input  1  memory accepts request
- imem_resp_valid_in  input  1  response data valid
- imem_resp_data_in  input  32  returned instruction word
- redirect_valid_in  input  1  branch/jump taken, from execute
- redirect_addr_in  input  32  redirect target
- inst_valid_out  output  1  queue head valid to decode
- inst_out  output  32  queue head instruction
- inst_pc_out  output  32  queue head PC
- inst_ready_in  input  1  decode consumes head

## Operation
- FSM states: REQ, WAIT, DRAIN. Reset → REQ, queue empty, req_pc register = 0.
- REQ: imem_req_valid_out = 1 iff queue count < QUEUE_DEPTH and redirect_valid_in = 0; imem_req_addr_out = pc_in. On valid&ready: pc_write_out = 1, pc_next_out = pc_in + 4 (mod 2^32), req_pc ← pc_in, → WAIT.
- WAIT: imem_req_valid_out = 0. On imem_resp_valid_in: push {req_pc, imem_resp_data_in}, → REQ.
- DRAIN: response of a squashed request pending. On imem_resp_valid_in: data discarded, → REQ.
- Redirect (highest priority, any state): pc_write_out = 1, pc_next_out = {redirect_addr_in[31:2], 2'b00}; queue flushed; no request issued this cycle. From WAIT: response in same cycle discarded, → REQ; otherwise → DRAIN. From REQ: stay REQ. From DRAIN: stay DRAIN.
- pc_write_out = 0 and pc_next_out = 0 in all other cycles.
- Queue: push on accepted non-squashed response, pop on inst_valid_out & inst_ready_in. Simultaneous push/pop at any count legal; count unchanged. Flush overrides push and pop in the same cycle.
- Overflow impossible by construction: request only issued with count < QUEUE_DEPTH and at most one outstanding; a push when full is a design error (assertion).
- Responses arriving in REQ (no outstanding request) are ignored (assertion).

## Timing
- Reset values: imem_req_valid_out 0, imem_req_addr_out 0 (masked), pc_write_out 0, pc_next_out 0, inst_valid_out 0, inst_out 0, inst_pc_out 0.
- First request in first cycle after reset_in deasserts, addr = pc_in (0 after PC register reset).
- Queue outputs registered: response at cycle N → inst_valid_out at N+1.
- With single-cycle memory (accept at N, response at N+1): issue rate one request per 2 cycles; next request at N+2.
- pc_write_out coincides with the accepting handshake cycle; PC register reflects new value at N+1.
- Reset asserted mid-transaction: FSM → REQ, queue emptied, outstanding response ignored via DRAIN-free restart (memory reset concurrently).

## Structure
- Package fetch_pkg: state enum {REQ, WAIT, DRAIN}, INST_W = 32, PC_INCR = 32'd4, queue entry struct {pc, inst}.
- Sub-module fetch_queue: synchronous FIFO of entries, parameter QUEUE_DEPTH, push/pop/flush, count, registered head; fetch_unit holds FSM, req_pc and PC-write logic.

## Test plan
- Sequential fetch, memory always ready, 1-cycle response, decode always ready: PCs 0,4,8,C delivered in order with correct data; pc_write_out once per request.
- Decode stalled (inst_ready_in = 0): after 2 instructions queued, imem_req_valid_out stays 0; releasing ready resumes at PC 8.
- Redirect to 0x0000_0103 while in WAIT, response 2 cycles later: queue flushed, pc_next_out = 0x0000_0100, late response discarded (DRAIN), next request addr 0x100.
- Redirect in same cycle as response in WAIT: response dropped, → REQ, no inst_valid_out next cycle.
- PC wrap: pc_in = 0xFFFF_FFFC accepted → pc_next_out = 0x0000_0000.
- Reset asserted while WAIT with queue holding 1 entry: next cycle all outputs at reset values, first post-reset request addr 0.
